// File: rtl/snake_input_ctrl_if.sv
// snake_input_ctrl_if: button/turn-queue signal bundle between the game core and the input front end
// Signals:
//   btn_raw   [3:0]  raw direction buttons (bit 0 up, 1 right, 2 down, 3 left), asynchronous
//   step             one-cycle pulse when the snake advances; pops one queued turn
//   clear            synchronous game restart
//   cur_dir   [1:0]  current heading (0 up, 1 right, 2 down, 3 left)
//   press_any        one-cycle pulse on any debounced press
//   q_count          number of queued turns
// Modports: master drives buttons/step/clear, slave is the input controller.
interface snake_input_ctrl_if #(
    parameter int QUEUE_DEPTH = 2
);
    logic [3:0]                   btn_raw;
    logic                         step;
    logic                         clear;
    logic [1:0]                   cur_dir;
    logic                         press_any;
    logic [$clog2(QUEUE_DEPTH):0] q_count;

    modport master (output btn_raw, step, clear, input cur_dir, press_any, q_count);
    modport slave  (input btn_raw, step, clear, output cur_dir, press_any, q_count);
endinterface

// File: rtl/snake_input_ctrl.sv
// snake_input_ctrl: synchronise, debounce and edge-detect the direction buttons, filter turns, queue them per step
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    snake_input_ctrl_if.slave: btn_raw/step/clear in, cur_dir/press_any/q_count out
// Parameters:
//   DEBOUNCE_BITS  debounce counter width; a button must stay changed for 2^DEBOUNCE_BITS cycles
//   QUEUE_DEPTH    turn-queue entries, power of two, at least 2
module snake_input_ctrl #(
    parameter int DEBOUNCE_BITS = 16,
    parameter int QUEUE_DEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    snake_input_ctrl_if.slave bus
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]                     sync1_q, sync2_q;
    logic [3:0]                     stable_q, stable_d, stable_dly_q;
    logic [3:0][DEBOUNCE_BITS-1:0]  cnt_q, cnt_d;
    logic [QUEUE_DEPTH-1:0][1:0]    mem_q, mem_d;
    logic [AW-1:0]                  rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]                  count_q, count_d;
    logic [1:0]                     dir_q, dir_d;
    logic                           press_q;
    logic [3:0]                     rise;
    logic [1:0]                     cand, ref_dir;
    logic                           pop, push;

    // A button only changes state after its synchronised value has differed for 2^DEBOUNCE_BITS consecutive cycles
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (&cnt_q[i]) stable_d[i] = sync2_q[i];
                else           cnt_d[i]    = cnt_q[i] + 1'b1;
            end
        end
    end

    assign rise = stable_q & ~stable_dly_q;

    always_comb begin
        cand    = rise[0] ? 2'd0 : rise[1] ? 2'd1 : rise[2] ? 2'd2 : 2'd3;
        // Filter against the newest queued turn so a double-tap is judged against where the snake will be heading
        ref_dir = (count_q != '0) ? mem_q[wr_q - AW'(1)] : dir_q;
        pop     = bus.step && (count_q != '0);
        // A same-cycle pop frees a slot, so a full queue still accepts the push
        push    = (|rise) && (cand != ref_dir) && (cand != (ref_dir ^ 2'd2)) &&
                  ((count_q != CW'(QUEUE_DEPTH)) || pop);
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        dir_d   = dir_q;
        if (bus.clear) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
            dir_d   = 2'd1;
        end else begin
            if (push) begin
                mem_d[wr_q] = cand;
                wr_d        = wr_q + AW'(1);
            end
            if (pop) begin
                dir_d = mem_q[rd_q];
                rd_d  = rd_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            cnt_q        <= '0;
            press_q      <= 1'b0;
            mem_q        <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            count_q      <= '0;
            dir_q        <= 2'd1;
        end else begin
            sync1_q      <= bus.btn_raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            press_q      <= |rise;
            mem_q        <= mem_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            count_q      <= count_d;
            dir_q        <= dir_d;
        end
    end

    assign bus.cur_dir   = dir_q;
    assign bus.press_any = press_q;
    assign bus.q_count   = count_q;
endmodule

// File: tb/tb_snake_input_ctrl.sv
// tb_snake_input_ctrl: scoreboard bench for snake_input_ctrl against a history/queue reference model
// Ports: none (top-level bench). Drives the interface master side; a negedge monitor pops expectations.
module tb_snake_input_ctrl;
    localparam int DB = 2;
    localparam int QD = 2;
    localparam int P  = 1 << DB;

    typedef struct {
        int    cur;
        int    cnt;
        string nm;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snake_input_ctrl_if #(.QUEUE_DEPTH(QD)) bus ();
    snake_input_ctrl #(.DEBOUNCE_BITS(DB), .QUEUE_DEPTH(QD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t       exp_state[$];
    exp_t       exp_dir[$];
    int         exp_press[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [3:0] hist[$];
    logic [3:0] m_stab, m_prev;
    int         mq[$];
    int         m_cur;

    // Raw samples before the first post-reset edge look like zero because the synchronisers reset to zero
    function automatic void model_reset();
        mq.delete();
        m_cur  = 1;
        m_stab = '0;
        m_prev = '0;
        hist.delete();
        for (int k = 0; k < P + 2; k++) hist.push_back(4'd0);
    endfunction

    // A button's debounced level flips once the raw level (two samples old) has held the other value for P samples
    task automatic model_edge(input logic [3:0] b, input bit s, input bit c);
        logic [3:0] rise, nstab;
        int         d, rf;
        bit         acc, flip;
        acc = 0;
        d   = 0;
        cyc++;
        hist.push_back(b);
        if (hist.size() > P + 3) void'(hist.pop_front());
        rise  = m_stab & ~m_prev;
        nstab = m_stab;
        for (int i = 0; i < 4; i++) begin
            flip = 1;
            for (int k = 2; k < P + 2; k++)
                if (hist[hist.size() - 1 - k][i] == m_stab[i]) flip = 0;
            if (flip) nstab[i] = ~m_stab[i];
        end
        m_prev = m_stab;
        m_stab = nstab;
        if (rise != 0) begin
            exp_press.push_back(cyc);
            for (int i = 3; i >= 0; i--) if (rise[i]) d = i;
            rf  = (mq.size() > 0) ? mq[$] : m_cur;
            acc = (d != rf) && (d != (rf ^ 2)) && ((mq.size() < QD) || (s && mq.size() > 0));
        end
        if (c) begin
            mq.delete();
            m_cur = 1;
        end else begin
            if (s && mq.size() > 0) m_cur = mq.pop_front();
            if (acc) mq.push_back(d);
        end
        exp_state.push_back('{m_cur, mq.size(), "state"});
    endtask

    task automatic cycle(input logic [3:0] b, input bit s, input bit c);
        bus.btn_raw = b;
        bus.step    = s;
        bus.clear   = c;
        @(posedge clk);
        model_edge(b, s, c);
        #1;
    endtask

    task automatic hold(input logic [3:0] b, input int n);
        repeat (n) cycle(b, 1'b0, 1'b0);
    endtask

    task automatic press(input logic [3:0] b);
        hold(b, 8);
        hold(4'd0, 8);
    endtask

    task automatic expect_now(input string nm, input int cur, input int cnt);
        exp_dir.push_back('{cur, cnt, nm});
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        model_reset();
        exp_state.delete();
        exp_press.delete();
        exp_state.push_back('{1, 0, "async_rst"});
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic void cmp(input exp_t e);
        checks++;
        if (int'(bus.cur_dir) != e.cur || int'(bus.q_count) != e.cnt) begin
            errors++;
            $display("FAIL %s @edge %0d: cur_dir=%0d q_count=%0d, expected cur_dir=%0d q_count=%0d",
                     e.nm, cyc, bus.cur_dir, bus.q_count, e.cur, e.cnt);
        end
    endfunction

    always @(negedge clk) begin : mon
        int p;
        if (exp_state.size() > 0) cmp(exp_state.pop_front());
        while (exp_dir.size() > 0) cmp(exp_dir.pop_front());
        if (bus.press_any) begin
            checks++;
            if (exp_press.size() == 0) begin
                errors++;
                $display("FAIL press_any: pulse at edge %0d, expected none", cyc);
            end else begin
                p = exp_press.pop_front();
                if (p != cyc) begin
                    errors++;
                    $display("FAIL press_any: pulse at edge %0d, expected edge %0d", cyc, p);
                end
            end
        end else if (exp_press.size() > 0 && exp_press[0] <= cyc) begin
            checks++;
            errors++;
            $display("FAIL press_any: no pulse at edge %0d, expected one", exp_press.pop_front());
        end
    end

    initial begin
        bus.btn_raw = '0;
        bus.step    = 1'b0;
        bus.clear   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(4'd0, 4);
        expect_now("reset", 1, 0);
        hold(4'b0001, 3);
        hold(4'd0, 10);
        expect_now("glitch", 1, 0);
        hold(4'b0001, 8);
        expect_now("press_up", 1, 1);
        hold(4'd0, 8);
        cycle(4'd0, 1'b1, 1'b0);
        expect_now("step_up", 0, 0);
        cycle(4'd0, 1'b0, 1'b1);
        press(4'b1000);
        expect_now("reversal", 1, 0);
        press(4'b0010);
        expect_now("redundant", 1, 0);
        cycle(4'd0, 1'b0, 1'b1);
        press(4'b0001);
        press(4'b1000);
        press(4'b0100);
        expect_now("full_drop", 1, 2);
        cycle(4'd0, 1'b1, 1'b0);
        expect_now("step1", 0, 1);
        cycle(4'd0, 1'b1, 1'b0);
        expect_now("step2", 3, 0);
        cycle(4'd0, 1'b0, 1'b1);
        press(4'b0101);
        expect_now("simultaneous", 1, 1);
        press(4'b1000);
        expect_now("fill", 1, 2);
        hold(4'b0001, 6);
        cycle(4'b0001, 1'b1, 1'b0);
        expect_now("push_pop_full", 0, 2);
        hold(4'd0, 8);
        cycle(4'd0, 1'b1, 1'b1);
        expect_now("clear_step", 1, 0);
        press(4'b0001);
        press(4'b1000);
        expect_now("pre_async", 1, 2);
        hold(4'b0001, 3);
        async_reset();
        hold(4'b0001, 8);
        expect_now("refire", 1, 1);
        hold(4'd0, 8);
        repeat (250) begin
            logic [3:0] b;
            int         n;
            b = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) b = '0;
            n = $urandom_range(1, 12);
            repeat (n) cycle(b, $urandom_range(0, 5) == 0, $urandom_range(0, 40) == 0);
        end
        hold(4'd0, 12);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/snake_input_ctrl.md
# snake_input_ctrl

Button front end for the snake game: it feeds the game core's movement logic from the four raw direction buttons on `ui_in`. Each button is synchronised, debounced and edge-detected. Presses are filtered against the current heading, because a snake may not reverse onto itself. Accepted turns go into a small queue that the game core drains one entry per snake step, so quick double-taps (e.g. up then left inside one step) are not lost.

## Interface

Parameters:
- `DEBOUNCE_BITS`, default 16: width of the per-button debounce counter. Stable period is 2^DEBOUNCE_BITS cycles.
- `QUEUE_DEPTH`, default 2: turn-queue entries, power of two, ≥ 2.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `btn_raw`  in  4: raw buttons, active high, asynchronous. Bit 0 up, 1 right, 2 down, 3 left.
- `step`  in  1: one-cycle pulse from the game core when the snake advances; pops one queued turn.
- `clear`  in  1: synchronous game restart. Empties the queue and sets heading to right.
- `cur_dir`  out  2: current heading. 0 up, 1 right, 2 down, 3 left.
- `press_any`  out  1: one-cycle pulse on any debounced rising edge, whether or not the turn is accepted. Used as the game-start trigger.
- `q_count`  out  clog2(QUEUE_DEPTH)+1: number of queued turns.

## Operation

Synchroniser and debounce, per button:
- 2-flop synchroniser gives `sync[i]`.
- Counter `cnt[i]` resets to 0 on any cycle where `sync[i] == stable[i]`.
- Otherwise `cnt[i]` increments. On the edge where `cnt[i]` is all-ones and `sync[i]` still differs, `stable[i]` takes `sync[i]` and `cnt[i]` returns to 0.
- A glitch shorter than 2^DEBOUNCE_BITS cycles never reaches `stable`.

Press event:
- `rise[i] = stable[i] & ~stable_d[i]`.
- Only one event is taken per cycle. Priority: up > right > down > left. Lower-priority simultaneous rises are discarded.
- `press_any` is registered and high for one cycle after any `rise`.

Turn filter:
- Reference heading `ref` is the newest queue entry when `q_count > 0` before any pop this cycle; otherwise it is `cur_dir`.
- Candidate `d` is rejected if `d == ref` (redundant) or `d == ref ^ 2` (reversal).
- Candidate `d` is also rejected if the queue is full and no pop occurs this cycle.
- Otherwise `d` is pushed.

Queue and step:
- Circular FIFO with read/write pointers that wrap modulo QUEUE_DEPTH.
- On `step` with `q_count > 0`: `cur_dir` takes the head entry and the head is popped.
- On `step` with an empty queue: `cur_dir` is unchanged.
- Push and pop in the same cycle are both performed. `q_count` is unchanged, and a full queue accepts the push.

Clear:
- `clear` overrides `step` and any push that cycle.
- Queue empties, `cur_dir` becomes 1 (right), and `q_count` becomes 0.
- Debounce and `stable` state are kept, so a button held through `clear` does not generate a new event.

## Timing

- Reset values: `cur_dir`=1, `press_any`=0, `q_count`=0. Synchronisers, `stable`, `stable_d`, counters and queue pointers are all 0.
- Press latency, with `btn_raw[i]` held high from edge 0:
  - `sync` high after 2 edges.
  - `stable` flips 2^DEBOUNCE_BITS edges later.
  - `press_any` and the queue write occur on the following edge.
  - Total: 3 + 2^DEBOUNCE_BITS edges. With DEBOUNCE_BITS=2 this is 7.
- `cur_dir` update: on the `step` edge itself; visible the cycle after `step`.
- Release follows the same debounce path and produces no event.
- `rst_n` low mid-debounce or mid-queue clears everything immediately (asynchronous).
- Button already held when `rst_n` rises: produces an event after the full latency.

## Test plan

Run all scenarios with DEBOUNCE_BITS=2 and QUEUE_DEPTH=2.

1. **Reset.** Hold `rst_n`=0, then release with all inputs 0 → `cur_dir`=1, `q_count`=0, `press_any` never pulses.
2. **Debounce.** `btn_raw`=0001 for 3 cycles, then 0 → no `press_any`. Then hold 0001 → `press_any` exactly 7 edges after assertion, `q_count`=1. Then `step` → `cur_dir`=0, `q_count`=0.
3. **Reversal and redundancy.** With `cur_dir`=1: press left (bit 3) → rejected, `q_count`=0, `press_any` still pulses. Press right → rejected.
4. **Double-tap and full queue.** With `cur_dir`=1: press up, then left, then down with no `step` → `q_count`=2 and down is dropped. Two `step`s → `cur_dir` goes 0, then 3.
5. **Simultaneous events.** Buttons 0101 rise together → only up is queued. With the queue full, a press coinciding with `step` → pop and push both occur, `q_count` stays 2. With `clear` and `step` together → `cur_dir`=1, `q_count`=0.
6. **Async reset mid-operation.** With 2 entries queued and a debounce in progress, pulse `rst_n` low for half a cycle → all outputs return to reset values immediately. The held button re-fires after 7 edges.
